// File: rtl/snow64_bfloat16_div_pkg.sv
// Shared BFloat16 types and constants for the FPU lane, extended with
// divider state encoding and restoring-division datapath widths.
package snow64_bfloat16_div_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] enc_exp;
        logic [6:0] enc_mantissa;
    } bfloat16_t;

    localparam int         BF16_BIAS         = 127;
    localparam logic [7:0] BF16_MAX_SAT_EXP  = 8'hFE;
    localparam logic [6:0] BF16_MAX_SAT_MANT = 7'h7F;

    typedef enum logic [1:0] {
        StDivIdle,
        StDivDividing,
        StDivFinishing
    } state_div_t;

    localparam int DIV_QUOT_W = 9;
    localparam int DIV_REM_W  = 10;

endpackage

// File: rtl/snow64_bfloat16_div_pack.sv
// Combinational normalise / saturate / flush of a raw 9-bit quotient into
// BFloat16; kept separate so a reciprocal unit can reuse it.
module snow64_bfloat16_div_pack
    import snow64_bfloat16_div_pkg::*;
(
    input  logic                  sign,
    input  logic [DIV_QUOT_W-1:0] quot,
    input  logic [7:0]            ea,
    input  logic [7:0]            eb,
    input  logic                  zero_a,
    input  logic                  zero_b,
    output logic [15:0]           data
);

    localparam logic signed [9:0] BIAS_S = 10'(BF16_BIAS);

    logic signed [9:0] e;
    logic [6:0]        mant;
    bfloat16_t         res;

    always_comb begin
        mant = quot[8] ? quot[7:1] : quot[6:0];
        // Quotient in [128,511]; a leading bit at Q[8] means ratio >= 1.
        e = $signed({2'b00, ea}) - $signed({2'b00, eb})
            + (quot[8] ? BIAS_S : (BIAS_S - 10'sd1));

        res.sign         = sign;
        res.enc_exp      = 8'h00;
        res.enc_mantissa = 7'h00;
        if (zero_b) begin
            res.enc_exp      = BF16_MAX_SAT_EXP;
            res.enc_mantissa = BF16_MAX_SAT_MANT;
        end else if (zero_a) begin
            res.enc_exp      = 8'h00;
        end else if (e <= 10'sd0) begin
            res.enc_exp      = 8'h00;
        end else if (e >= 10'sd255) begin
            res.enc_exp      = BF16_MAX_SAT_EXP;
            res.enc_mantissa = BF16_MAX_SAT_MANT;
        end else begin
            res.enc_exp      = e[7:0];
            res.enc_mantissa = mant;
        end
        data = res;
    end

endmodule

// File: rtl/snow64_bfloat16_div.sv
// Iterative truncating BFloat16 divider: restoring division, one quotient
// bit per clock, behind the start / data_valid / can_accept_cmd handshake.
module snow64_bfloat16_div
    import snow64_bfloat16_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_start,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_data_valid,
    output logic        out_can_accept_cmd,
    output logic [15:0] out_data
);

    // state          | meaning
    // StDivIdle      | waiting for in_start; result outputs held
    // StDivDividing  | producing one quotient bit per edge (9 edges)
    // StDivFinishing | packing quotient into out_data, pulse valid next

    state_div_t state, state_nxt;

    bfloat16_t op_a, op_b;
    logic      a_is_zero, b_is_zero;

    logic                  sign;
    logic [7:0]            ea, eb, sb;
    logic [DIV_REM_W-1:0]  rem, rem_diff;
    logic [DIV_QUOT_W-1:0] quot;
    logic [3:0]            count;
    logic                  zero_a, zero_b;
    logic                  q_bit;
    logic [15:0]           packed_data;

    assign op_a      = in_a;
    assign op_b      = in_b;
    assign a_is_zero = (op_a.enc_exp == 8'h00);
    assign b_is_zero = (op_b.enc_exp == 8'h00);

    assign out_can_accept_cmd = (state == StDivIdle);

    assign q_bit    = (rem >= {2'b00, sb});
    assign rem_diff = q_bit ? (rem - {2'b00, sb}) : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= StDivIdle;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            StDivIdle:
                if (in_start)
                    state_nxt = (a_is_zero || b_is_zero) ? StDivFinishing : StDivDividing;
            StDivDividing:
                if (count == 4'd0) state_nxt = StDivFinishing;
            StDivFinishing:
                state_nxt = StDivIdle;
            default:
                state_nxt = StDivIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign           <= 1'b0;
            ea             <= 8'h00;
            eb             <= 8'h00;
            sb             <= 8'h00;
            rem            <= '0;
            quot           <= '0;
            count          <= 4'd0;
            zero_a         <= 1'b0;
            zero_b         <= 1'b0;
            out_data       <= 16'h0000;
            out_data_valid <= 1'b0;
        end else begin
            out_data_valid <= (state == StDivFinishing);
            case (state)
                StDivIdle: begin
                    if (in_start) begin
                        sign   <= op_a.sign ^ op_b.sign;
                        ea     <= op_a.enc_exp;
                        eb     <= op_b.enc_exp;
                        sb     <= {1'b1, op_b.enc_mantissa};
                        rem    <= {3'b001, op_a.enc_mantissa};
                        quot   <= '0;
                        count  <= 4'(DIV_QUOT_W - 1);
                        zero_a <= a_is_zero;
                        zero_b <= b_is_zero;
                    end
                end
                StDivDividing: begin
                    // Remainder stays below 2*sb, so dropping the top bit is lossless.
                    rem   <= {rem_diff[DIV_REM_W-2:0], 1'b0};
                    quot  <= {quot[DIV_QUOT_W-2:0], q_bit};
                    count <= count - 4'd1;
                end
                StDivFinishing: begin
                    out_data <= packed_data;
                end
                default: ;
            endcase
        end
    end

    snow64_bfloat16_div_pack u_pack (
        .sign   (sign),
        .quot   (quot),
        .ea     (ea),
        .eb     (eb),
        .zero_a (zero_a),
        .zero_b (zero_b),
        .data   (packed_data)
    );

endmodule
